// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of sync_fifo.
// N producers compete through valid/ready handshakes. The winner's data is
// registered onto the FIFO write port one cycle after the grant. A credit
// counter reserves a FIFO entry at grant time and releases it on an observed
// read, so the registered write path can never overrun the FIFO.
module fifo_wr_arbiter #(
  parameter int N     = 4,
  parameter int W     = 16,
  parameter int DEPTH = 8,
  localparam int OCC_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rstn,          // synchronous, active-high
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_data,
  output logic [N-1:0]     req_ready,
  output logic             fifo_wr_en,
  output logic [W-1:0]     fifo_din,
  input  logic             fifo_full,
  input  logic             fifo_rd_en,
  input  logic             fifo_empty,
  output logic [OCC_W-1:0] occupancy,
  output logic             overflow_err
);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             wr_en_q, wr_en_d;
  logic [W-1:0]     din_q, din_d;
  logic             err_q, err_d;

  logic             eligible;
  logic             found;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] cand;
  logic [N-1:0]     grant;
  logic             transfer;
  logic             rd_ok;
  int               idx;

  // Saturating credit update: +1 on a grant, -1 on a real read, clamped to
  // the range [0, DEPTH].
  function automatic logic [OCC_W-1:0] credit_next(input logic [OCC_W-1:0] occ,
                                                   input logic inc,
                                                   input logic dec);
    logic [OCC_W-1:0] res;
    res = occ;
    if (inc && !dec) begin
      if (occ < OCC_W'(DEPTH)) res = occ + 1'b1;
    end else if (dec && !inc) begin
      if (occ != '0) res = occ - 1'b1;
    end
    return res;
  endfunction

  // Cyclic priority scan starting at the round-robin pointer; grant is
  // suppressed during reset and whenever every FIFO entry is reserved.
  always_comb begin
    eligible = !rstn && (occ_q < OCC_W'(DEPTH));
    found    = 1'b0;
    winner   = '0;
    cand     = '0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx  = (int'(ptr_q) + k) % N;
      cand = PTR_W'(idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    grant = '0;
    if (eligible && found) grant[winner] = 1'b1;
  end

  // Next-state for pointer, registered write port, credits and error flag.
  always_comb begin
    transfer = |(req_valid & grant);
    rd_ok    = fifo_rd_en & ~fifo_empty;
    ptr_d    = ptr_q;
    din_d    = din_q;
    if (transfer) begin
      ptr_d = PTR_W'((int'(winner) + 1) % N);
      din_d = req_data[int'(winner)*W +: W];
    end
    wr_en_d = transfer;
    occ_d   = credit_next(occ_q, transfer, rd_ok);
    err_d   = err_q | (wr_en_q & fifo_full);
  end

  // ---- stage boundary: grant -> FIFO write port (1 cycle) ----
  // State registers; reset also drops any in-flight write.
  always_ff @(posedge clk) begin
    if (rstn) begin
      ptr_q   <= '0;
      occ_q   <= '0;
      wr_en_q <= 1'b0;
      din_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      occ_q   <= occ_d;
      wr_en_q <= wr_en_d;
      din_q   <= din_d;
      err_q   <= err_d;
    end
  end

  assign req_ready    = grant;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_din     = din_q;
  assign occupancy    = occ_q;
  assign overflow_err = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: behavioural model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fifo_wr_arbiter;
  localparam int N     = 4;
  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int OCC_W = 4;

  logic             clk;
  logic             rstn;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             fifo_wr_en;
  logic [W-1:0]     fifo_din;
  logic             fifo_full;
  logic             fifo_rd_en;
  logic             fifo_empty;
  logic [OCC_W-1:0] occupancy;
  logic             overflow_err;

  logic full_force;
  int   tf_fill;
  int   n_chk;
  int   n_fail;
  logic chk_en;

  // model state
  int          m_ptr;
  int          m_occ;
  logic        m_wr;
  logic [W-1:0] m_din;
  logic        m_err;

  fifo_wr_arbiter #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .fifo_full(fifo_full), .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty),
    .occupancy(occupancy), .overflow_err(overflow_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Simple FIFO fill model driving the status flags.
  assign fifo_full  = full_force | (tf_fill == DEPTH);
  assign fifo_empty = (tf_fill == 0);

  always @(posedge clk) begin
    if (rstn) tf_fill <= 0;
    else tf_fill <= tf_fill + (fifo_wr_en ? 1 : 0) - ((fifo_rd_en && !fifo_empty) ? 1 : 0);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected grant: first valid requester at or after ptr, cyclically.
  function automatic logic [N-1:0] mdl_grant(input int ptr, input int occ,
                                             input logic [N-1:0] v, input logic rst);
    if (rst || occ >= DEPTH) return '0;
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return N'(1) << ((ptr + k) % N);
    return '0;
  endfunction

  // Model update on each clock edge from the inputs held during the cycle.
  always @(posedge clk) begin
    logic [N-1:0] g;
    logic rd;
    if (rstn) begin
      m_ptr = 0; m_occ = 0; m_wr = 1'b0; m_din = '0; m_err = 1'b0;
    end else begin
      g  = mdl_grant(m_ptr, m_occ, req_valid, 1'b0);
      rd = fifo_rd_en && !fifo_empty;
      m_err = m_err | (m_wr & fifo_full);
      m_wr  = (g != '0);
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          m_din = req_data[i*W +: W];
          m_ptr = (i + 1) % N;
          m_occ = m_occ + 1;
        end
      end
      if (rd && m_occ > 0) m_occ = m_occ - 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("mdl_req_ready", 32'(req_ready), 32'(mdl_grant(m_ptr, m_occ, req_valid, rstn)));
      check("mdl_wr_en", 32'(fifo_wr_en), 32'(m_wr));
      if (m_wr) check("mdl_din", 32'(fifo_din), 32'(m_din));
      check("mdl_occupancy", 32'(occupancy), 32'(m_occ));
      check("mdl_overflow_err", 32'(overflow_err), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] seq1 [8];

  initial begin
    n_chk = 0; n_fail = 0; chk_en = 1'b0;
    rstn = 1'b1; req_valid = 4'b1111; fifo_rd_en = 1'b0; full_force = 1'b0;
    req_data = '0;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 16'hA0A0 + 16'(i);
    seq1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    // reset state
    tick(); chk_en = 1'b1;
    tick();
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_din", 32'(fifo_din), 32'd0);
    check("rst_err", 32'(overflow_err), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    rstn = 1'b0;

    // 1: fairness and credit limit
    for (int g = 0; g < 8; g++) begin
      #1 check("t1_grant", 32'(req_ready), 32'(seq1[g]));
      tick();
      check("t1_wr_en", 32'(fifo_wr_en), 32'd1);
      check("t1_din", 32'(fifo_din), 32'(16'hA0A0 + 16'(g % 4)));
    end
    check("t1_occ_full", 32'(occupancy), 32'd8);
    check("t1_no_grant", 32'(req_ready), 32'd0);
    req_valid = 4'b0000; fifo_rd_en = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("t1_drained", 32'(occupancy), 32'd0);
    fifo_rd_en = 1'b0;

    // 2: single requester, then wrap to port 3 before port 0
    req_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1 check("t2_single", 32'(req_ready), 32'b0100);
      tick();
    end
    req_valid = 4'b1001;
    #1 check("t2_port3_first", 32'(req_ready), 32'b1000);
    tick();
    check("t2_port0_next", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    check("t2_occ", 32'(occupancy), 32'd5);

    // 3: transfer and read together, then read at the credit limit
    req_valid = 4'b0010; fifo_rd_en = 1'b1;
    #1 check("t3_grant_p1", 32'(req_ready), 32'b0010);
    tick();
    check("t3_occ_same", 32'(occupancy), 32'd5);
    fifo_rd_en = 1'b0; req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) tick();
    check("t3_occ8", 32'(occupancy), 32'd8);
    fifo_rd_en = 1'b1;
    #1 check("t3_full_read_no_grant", 32'(req_ready), 32'd0);
    tick();
    check("t3_occ7", 32'(occupancy), 32'd7);
    check("t3_grant_resumes", 32'(req_ready), 32'b0010);
    fifo_rd_en = 1'b0;
    tick();
    check("t3_occ8_again", 32'(occupancy), 32'd8);
    req_valid = 4'b0000; fifo_rd_en = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("t3_drained", 32'(occupancy), 32'd0);

    // 4: read while empty is ignored
    tick();
    check("t4_occ0_a", 32'(occupancy), 32'd0);
    tick();
    check("t4_occ0_b", 32'(occupancy), 32'd0);
    fifo_rd_en = 1'b0;

    // 5: reset mid-stream at occupancy 5, ptr 2
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) tick();
    req_valid = 4'b0010;
    #1 check("t5_grant_p1", 32'(req_ready), 32'b0010);
    tick();
    check("t5_occ5", 32'(occupancy), 32'd5);
    req_valid = 4'b1111; rstn = 1'b1;
    #1 check("t5_ready_in_rst", 32'(req_ready), 32'd0);
    tick();
    check("t5_occ_cleared", 32'(occupancy), 32'd0);
    check("t5_wr_dropped", 32'(fifo_wr_en), 32'd0);
    check("t5_ready_rst", 32'(req_ready), 32'd0);
    rstn = 1'b0;
    #1 check("t5_port0_prio", 32'(req_ready), 32'b0001);

    // 6: sticky overflow error
    full_force = 1'b1;
    tick();
    check("t6_err_not_yet", 32'(overflow_err), 32'd0);
    req_valid = 4'b0000;
    tick();
    check("t6_err_set", 32'(overflow_err), 32'd1);
    full_force = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("t6_err_sticky", 32'(overflow_err), 32'd1);
    rstn = 1'b1;
    tick();
    check("t6_err_cleared", 32'(overflow_err), 32'd0);
    rstn = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of sync_fifo among N producers. Each producer uses a valid/ready handshake. Granted data is registered onto the FIFO write port one cycle later. An internal credit counter tracks FIFO occupancy from issued writes and observed reads, so `fifo_full` is never overrun despite the registered write path.

Parameters:
- N, 4, number of requesters (2..8)
- W, 16, data width, matches sync_fifo `din`
- DEPTH, 8, sync_fifo depth in entries; credit limit

Ports:
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  reset. Port name follows the codebase convention, but polarity is fixed: synchronous, active-high (1 = reset), sampled on posedge clk.
- req_valid  in  N  per-requester valid
- req_data  in  N*W  requester i data in bits [i*W +: W]
- req_ready  out  N  per-requester grant, one-hot or zero (combinational)
- fifo_wr_en  out  1  registered write strobe to sync_fifo
- fifo_din  out  W  registered write data to sync_fifo
- fifo_full  in  1  sync_fifo full flag
- fifo_rd_en  in  1  read strobe seen by sync_fifo (monitored only)
- fifo_empty  in  1  sync_fifo empty flag
- occupancy  out  clog2(DEPTH+1)  credit count (reserved entries)
- overflow_err  out  1  sticky: write issued while fifo_full

Behaviour:
- Reset (rstn=1 at posedge), next cycle:
  - occupancy=0, rr pointer=0, fifo_wr_en=0, fifo_din=0, overflow_err=0.
  - req_ready=0 while rstn=1.
- Arbitration (combinational):
  - Eligible when occupancy < DEPTH.
  - Winner = first i with req_valid[i]=1, scanning cyclically from ptr: ptr, ptr+1, ..., ptr+N-1 mod N.
  - req_ready[winner]=1; all other bits 0.
  - Not eligible, or no valid request: req_ready=0.
- Transfer:
  - Occurs when req_valid[i] & req_ready[i]; at most one per cycle.
  - req_ready does not depend on req_ready of other ports. Requesters may hold valid indefinitely.
- Pointer:
  - On transfer, ptr <= (winner+1) mod N.
  - Otherwise ptr holds; an idle cycle does not move ptr.
- Write path, latency 1 cycle:
  - fifo_wr_en <= transfer.
  - fifo_din <= req_data of the winner on transfer; otherwise fifo_din holds its last value.
- Credit counter:
  - rd_ok = fifo_rd_en & ~fifo_empty.
  - occupancy <= occupancy + transfer - rd_ok.
  - Simultaneous transfer and rd_ok: occupancy unchanged.
  - A read while fifo_empty=1 is ignored.
  - Counter saturates at 0 and never exceeds DEPTH, enforced by grant gating.
  - Counting at grant time keeps occupancy >= true FIFO fill, so the arbiter is conservative.
- Full boundary:
  - At occupancy==DEPTH there is no grant, even if a read occurs that same cycle.
  - Granting resumes the cycle after occupancy drops.
- Error:
  - overflow_err <= 1 when fifo_wr_en & fifo_full.
  - Cleared only by reset.
  - Cannot occur with a correctly wired FIFO of matching DEPTH.
- Reset mid-operation:
  - An in-flight registered write is dropped (fifo_wr_en=0 next cycle).
  - Credits are cleared; the FIFO is reset together with the arbiter.

Test Plan (N=4, W=16, DEPTH=8):
1. Fairness and credit limit.
   - Stimulus: all req_valid=4'b1111, no reads, distinct data per port.
   - Response: grants follow ports 0,1,2,3,0,1,2,3. fifo_wr_en pulses one cycle after each grant with matching fifo_din. After 8 grants occupancy=8, req_ready=0, and fifo_full is never violated.
2. Single requester.
   - Stimulus: req_valid=4'b0100 for 3 cycles.
   - Response: req_ready=4'b0100 each cycle and ptr=3. Then req_valid=4'b1001 → port 3 granted first, then port 0.
3. Simultaneous transfer and read.
   - Stimulus: occupancy=5, a transfer with fifo_rd_en=1 and fifo_empty=0.
   - Response: occupancy stays 5.
   - Stimulus: occupancy=8 with a read.
   - Response: no grant that cycle, occupancy=7, grant resumes the next cycle.
4. Ignored read.
   - Stimulus: fifo_rd_en=1 with fifo_empty=1 at occupancy=0.
   - Response: occupancy stays 0, no underflow.
5. Reset mid-stream.
   - Stimulus: rstn=1 for one cycle at occupancy=5, ptr=2, with a transfer pending.
   - Response: next cycle occupancy=0, fifo_wr_en=0, req_ready=0. After release, port 0 has priority.
6. Error flag.
   - Stimulus: force fifo_full=1 while a transfer occurs.
   - Response: overflow_err=1 two cycles after the grant and stays 1 until reset.
